// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised sync FIFO.
// Compile-time option: FIFO_FWFT_EN (see sync_fifo_param) selects first-word-fall-through reads.
package fifo_pkg;

  // Defaults matching the legacy fixed-size buffer's word width.
  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefDepth = 8;

  // Smallest k such that 2**k >= n. Used for pointer and occupancy widths.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Pointers wrap naturally only when the depth is a power of two.
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit af_lvl_ok(input int unsigned af_lvl, input int unsigned depth);
    return (af_lvl >= 1) && (af_lvl <= depth);
  endfunction

  function automatic bit ae_lvl_ok(input int unsigned ae_lvl, input int unsigned depth);
    return ae_lvl <= (depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the sync FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
  parameter int unsigned DataW = 16,
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: combinational lookup at the read pointer.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost
// flags, sticky overflow/underflow flags and synchronous flush.
// Compile-time option: define FIFO_FWFT_EN for first-word-fall-through reads;
// otherwise rd_data is a register loaded by each accepted read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             rd_en,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_valid,
  output logic                             fifo_full,
  output logic                             fifo_empty,
  output logic                             almost_full,
  output logic                             almost_empty,
  output logic [fifo_clog2(DEPTH+1)-1:0]   count,
  output logic                             ovf,
  output logic                             udf
);

  localparam int unsigned PtrW = fifo_clog2(DEPTH);
  localparam int unsigned CntW = fifo_clog2(DEPTH + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAf   = CntW'(AF_LVL);
  localparam logic [CntW-1:0] CntAe   = CntW'(AE_LVL);

  // Reject illegal configurations at elaboration.
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (!af_lvl_ok(AF_LVL, DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LVL must lie in 1..DEPTH");
  end
  if (!ae_lvl_ok(AE_LVL, DEPTH)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LVL must lie in 0..DEPTH-1");
  end

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Status flags decode straight from the occupancy register.
  always_comb begin
    fifo_full    = (count_q == CntFull);
    fifo_empty   = (count_q == '0);
    almost_full  = (count_q >= CntAf);
    almost_empty = (count_q <= CntAe);
    count        = count_q;
    ovf          = ovf_q;
    udf          = udf_q;
  end

  // Acceptance uses pre-edge flags; a flush suppresses both ports.
  always_comb begin
    wr_acc = wr_en & ~fifo_full & ~clr;
    rd_acc = rd_en & ~fifo_empty & ~clr;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      // Attempts are flagged even though the rejected side has no effect.
      ovf_d = ovf_q | (wr_en & fifo_full);
      udf_d = udf_q | (rd_en & fifo_empty);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DataW (DATA_W),
    .Depth (DEPTH),
    .AddrW (PtrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head word is presented as soon as it is stored; rd_en pops it.
  always_comb begin
    rd_data  = mem_rdata;
    rd_valid = ~fifo_empty;
  end
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Load the popped word; hold it otherwise (including across a flush).
  always_comb begin
    rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
    rd_valid_d = rd_acc;
  end

  // Registered read data and its one-cycle valid strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Drive the read outputs from the register.
  always_comb begin
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
  end
`endif

  // Structural invariants: occupancy bounded and consistent with the pointers.
  a_count_range : assert property (@(posedge clk) disable iff (!rstn)
    count_q <= CntFull);
  a_full_empty_excl : assert property (@(posedge clk) disable iff (!rstn)
    !(fifo_full && fifo_empty));
  a_ptr_count : assert property (@(posedge clk) disable iff (!rstn)
    PtrW'(wr_ptr_q - rd_ptr_q) == PtrW'(count_q));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=16, DEPTH=8, AF_LVL=6, AE_LVL=2).
// Covers both read modes; FIFO_FWFT_EN selects the fall-through expectations.
module tb_sync_fifo_param;

  localparam int unsigned DP = 8;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 2;

  logic        clk = 1'b0;
  logic        rstn, clr, wr_en, rd_en;
  logic [15:0] wr_data, rd_data;
  logic        rd_valid, fifo_full, fifo_empty, almost_full, almost_empty, ovf, udf;
  logic [3:0]  count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: a queue of stored words plus the observable side state.
  logic [15:0] q[$];
  logic        m_ovf, m_udf, m_rv;
  logic [15:0] m_rdat;

  typedef struct {
    logic        clr;
    logic        wr;
    logic [15:0] wd;
    logic        rd;
    int unsigned cnt;
    logic        ovf;
    logic        udf;
    logic        rv;
    logic [15:0] rdat;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_param #(
    .DATA_W (16),
    .DEPTH  (DP),
    .AF_LVL (AF),
    .AE_LVL (AE)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic w, input logic [15:0] d,
                              input logic r, input int unsigned cnt, input logic eo,
                              input logic eu, input logic rv, input logic [15:0] rdat);
    vec_t v;
    v.clr = c; v.wr = w; v.wd = d; v.rd = r; v.cnt = cnt;
    v.ovf = eo; v.udf = eu; v.rv = rv; v.rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_rdat = 16'h0000;
  endtask

  task automatic model_step(input logic c, input logic w, input logic [15:0] d, input logic r);
    bit full, empty;
    if (c) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
    end else begin
      full  = (q.size() == DP);
      empty = (q.size() == 0);
      if (w && full)  m_ovf = 1'b1;
      if (r && empty) m_udf = 1'b1;
      m_rv = 1'b0;
      if (r && !empty) begin
        m_rdat = q.pop_front();
        m_rv   = 1'b1;
      end
      if (w && !full) q.push_back(d);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and stop #1 after the edge.
  task automatic drive(input logic c, input logic w, input logic [15:0] d, input logic r);
    clr = c; wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    #1;
    model_step(c, w, d, r);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " full"}, 32'(fifo_full), 32'(q.size() == DP));
    chk({tag, " empty"}, 32'(fifo_empty), 32'(q.size() == 0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(q.size() >= AF));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, " udf"}, 32'(udf), 32'(m_udf));
`ifdef FIFO_FWFT_EN
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, " rd_data"}, 32'(rd_data), 32'(q[0]));
`else
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, " rd_data"}, 32'(rd_data), 32'(m_rdat));
`endif
  endtask

  // Asynchronous reset asserted between edges must clear state immediately.
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, " full"}, 32'(fifo_full), 32'd0);
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, " almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, " ovf"}, 32'(ovf), 32'd0);
    chk({tag, " udf"}, 32'(udf), 32'd0);
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
`ifndef FIFO_FWFT_EN
    chk({tag, " rd_data"}, 32'(rd_data), 32'd0);
`endif
    #2 rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    int unsigned wp, rp;
    logic [15:0] exp_d;

    // Directed vectors: fill, overflow, full/empty collisions, drain, flush.
    for (int i = 1; i <= 8; i++) begin
      vecs.push_back(mk(1'b0, 1'b1, 16'(i), 1'b0, i, 1'b0, 1'b0, 1'b0, 16'h0000));
    end
    vecs.push_back(mk(1'b0, 1'b1, 16'hDEAD, 1'b0, 8, 1'b1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b1, 16'h1234, 1'b1, 7, 1'b1, 1'b0, 1'b1, 16'h0001));
    for (int k = 2; k <= 8; k++) begin
      vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 8 - k, 1'b1, 1'b0, 1'b1, 16'(k)));
    end
    vecs.push_back(mk(1'b0, 1'b1, 16'h00AA, 1'b1, 1, 1'b1, 1'b1, 1'b0, 16'h0008));
    vecs.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0008));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b1, 1'b0, 16'h0008));
    vecs.push_back(mk(1'b1, 1'b1, 16'h5555, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0008));
    vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0008));

    rstn = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0000;
    model_reset();
    #12;
    chk("reset empty", 32'(fifo_empty), 32'd1);
    chk("reset count", 32'(count), 32'd0);
    chk("reset almost_empty", 32'(almost_empty), 32'd1);
    chk("reset almost_full", 32'(almost_full), 32'd0);
    chk("reset full", 32'(fifo_full), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset udf", 32'(udf), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("reset rd_data", 32'(rd_data), 32'd0);
`endif
    rstn = 1'b1;

`ifndef FIFO_FWFT_EN
    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].wr, vecs[i].wd, vecs[i].rd);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d full", i), 32'(fifo_full), 32'(vecs[i].cnt == DP));
      chk($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'(vecs[i].cnt == 0));
      chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(vecs[i].cnt >= AF));
      chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].cnt <= AE));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d udf", i), 32'(udf), 32'(vecs[i].udf));
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rdat));
    end
`else
    // Fall-through: a stored word is visible one edge later without rd_en.
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("fwft rd_valid", 32'(rd_valid), 32'd1);
    chk("fwft rd_data", 32'(rd_data), 32'hBEEF);
    drive(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("fwft pop empty", 32'(fifo_empty), 32'd1);
    chk("fwft pop rd_valid", 32'(rd_valid), 32'd0);
    chk("fwft pop count", 32'(count), 32'd0);
`endif

    // Streaming with a two-word lead across many pointer wraps.
    drive(1'b1, 1'b0, 16'h0000, 1'b0);
    drive(1'b0, 1'b1, 16'h1000, 1'b0);
    drive(1'b0, 1'b1, 16'h1001, 1'b0);
    for (int j = 0; j < 100; j++) begin
      drive(1'b0, 1'b1, 16'(32'h1002 + j), 1'b1);
`ifdef FIFO_FWFT_EN
      exp_d = 16'(32'h1001 + j);
`else
      exp_d = 16'(32'h1000 + j);
`endif
      chk($sformatf("stream%0d count", j), 32'(count), 32'd2);
      chk($sformatf("stream%0d rd_valid", j), 32'(rd_valid), 32'd1);
      chk($sformatf("stream%0d rd_data", j), 32'(rd_data), 32'(exp_d));
    end

    // Mid-operation asynchronous reset with words in flight.
    drive(1'b0, 1'b1, 16'h7777, 1'b1);
    async_reset("midreset");
    drive(1'b0, 1'b0, 16'h0000, 1'b0);
    check_model("post-reset");

    // Randomized traffic against the queue model, biased toward full/empty in turn.
    wp = 50; rp = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        unique case ((i / 150) % 4)
          0: begin wp = 85; rp = 20; end
          1: begin wp = 20; rp = 85; end
          2: begin wp = 60; rp = 60; end
          default: begin wp = 95; rp = 95; end
        endcase
      end
      if (i == 700) async_reset("randreset");
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < wp), 16'($urandom),
            ($urandom_range(0, 99) < rp));
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
